// File: rtl/fp_sched_pkg.sv
// Shared widths, default sizing and small helpers for the fp16 add scheduler.
package fp_sched_pkg;

    localparam int FP16_W = 16;
    localparam int FP32_W = 32;

    localparam int DEF_N_REQ      = 4;
    localparam int DEF_ADD_LAT    = 1;
    localparam int DEF_FIFO_DEPTH = 4;

    // Canonical quiet NaN produced for invalid additions.
    localparam logic [FP32_W-1:0] FP32_QNAN = 32'h7FC0_0000;

    // Increment that wraps at an arbitrary (not necessarily power-of-two) modulus.
    function automatic int wrap_inc(input int value, input int modulus);
        return (value + 1 >= modulus) ? 0 : value + 1;
    endfunction

endpackage

// File: rtl/fp_16_to_32_adder.sv
// Adds two fp16 operands and returns the fp32 sum, LAT registered stages deep.
// Both operands are converted exactly to a 41-bit fixed-point magnitude in
// units of 2^-24 (the fp16 subnormal step), summed exactly, then normalised
// into fp32 with round-to-nearest-even. Inf/NaN follow IEEE rules.
module fp_16_to_32_adder
    import fp_sched_pkg::*;
#(
    parameter int LAT = DEF_ADD_LAT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [FP16_W-1:0] fp_data_1,
    input  logic [FP16_W-1:0] fp_data_2,
    output logic [FP32_W-1:0] data_out
);

    // Magnitude of a finite fp16 value as an integer multiple of 2^-24.
    function automatic logic [39:0] fp16_mag(input logic [14:0] x);
        if (x[14:10] == 5'd0) begin
            return {30'd0, x[9:0]};
        end
        return 40'({1'b1, x[9:0]}) << (x[14:10] - 5'd1);
    endfunction

    logic              nan_1, nan_2, inf_1, inf_2;
    logic [39:0]       mag_1, mag_2;
    logic [40:0]       mag_s;
    logic              sign_s;
    logic [5:0]        lead;
    logic [40:0]       norm;
    logic              round_up;
    logic [30:0]       exp_mant;
    logic [FP32_W-1:0] sum_comb;
    logic [FP32_W-1:0] pipe [LAT];

    // Exact fixed-point sum, normalisation and rounding.
    always_comb begin
        nan_1    = (fp_data_1[14:10] == 5'h1F) && (fp_data_1[9:0] != 10'd0);
        nan_2    = (fp_data_2[14:10] == 5'h1F) && (fp_data_2[9:0] != 10'd0);
        inf_1    = (fp_data_1[14:10] == 5'h1F) && (fp_data_1[9:0] == 10'd0);
        inf_2    = (fp_data_2[14:10] == 5'h1F) && (fp_data_2[9:0] == 10'd0);
        mag_1    = fp16_mag(fp_data_1[14:0]);
        mag_2    = fp16_mag(fp_data_2[14:0]);
        mag_s    = '0;
        sign_s   = 1'b0;
        lead     = '0;
        norm     = '0;
        round_up = 1'b0;
        exp_mant = '0;
        sum_comb = '0;

        if (fp_data_1[15] == fp_data_2[15]) begin
            mag_s  = {1'b0, mag_1} + {1'b0, mag_2};
            sign_s = fp_data_1[15];
        end else if (mag_1 >= mag_2) begin
            mag_s  = {1'b0, mag_1 - mag_2};
            // Exact cancellation yields +0.
            sign_s = (mag_1 == mag_2) ? 1'b0 : fp_data_1[15];
        end else begin
            mag_s  = {1'b0, mag_2 - mag_1};
            sign_s = fp_data_2[15];
        end

        for (int i = 0; i < 41; i++) begin
            if (mag_s[i]) lead = 6'(i);
        end
        // Shift the leading one out of the top so the fraction is left-aligned.
        norm     = mag_s << (6'd41 - lead);
        round_up = norm[17] && (norm[18] || (|norm[16:0]));
        // A rounding carry out of the mantissa bumps the exponent naturally.
        exp_mant = {({2'b00, lead} + 8'd103), norm[40:18]} + {30'd0, round_up};

        if (nan_1 || nan_2 || (inf_1 && inf_2 && (fp_data_1[15] != fp_data_2[15]))) begin
            sum_comb = FP32_QNAN;
        end else if (inf_1) begin
            sum_comb = {fp_data_1[15], 8'hFF, 23'd0};
        end else if (inf_2) begin
            sum_comb = {fp_data_2[15], 8'hFF, 23'd0};
        end else if (mag_s == '0) begin
            sum_comb = {sign_s, 31'd0};
        end else begin
            sum_comb = {sign_s, exp_mant};
        end
    end

    // Result delay line; the last stage is the registered output.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < LAT; s++) pipe[s] <= '0;
        end else begin
            pipe[0] <= sum_comb;
            for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
        end
    end

    assign data_out = pipe[LAT-1];

endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter feeding a shared fp16->fp32 adder, with a credit-guarded
// result FIFO that returns sums in issue order tagged with the requester index.
// FIFO_DEPTH must be at least ADD_LAT+1 so a full pipeline always fits.
//
// Handshakes: a beat moves on any cycle where valid and ready are both high at
// the rising edge. Producers may raise or drop valid freely before the beat.
// req_ready is derived combinationally from req_valid and is one-hot or zero;
// res_data/res_id are held stable while res_valid is high and res_ready low.
module fp_add_arbiter
    import fp_sched_pkg::*;
#(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int ADD_LAT    = DEF_ADD_LAT,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int ID_W      = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*FP16_W-1:0] req_a,
    input  logic [N_REQ*FP16_W-1:0] req_b,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [FP32_W-1:0]       res_data,
    output logic [ID_W-1:0]         res_id,
    output logic                    busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_id;
    logic              grant;
    logic              can_issue;
    int                inflight;
    int                credits;
    int                idx;
    logic [FP16_W-1:0] add_a, add_b;
    logic [FP32_W-1:0] add_sum;

    logic              tag_valid [ADD_LAT];
    logic [ID_W-1:0]   tag_id    [ADD_LAT];

    logic [FP32_W-1:0] fifo_data [FIFO_DEPTH];
    logic [ID_W-1:0]   fifo_id   [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic              push, pop;

    // Credits: every slot not already holding or promised to a result.
    always_comb begin
        inflight = 0;
        for (int s = 0; s < ADD_LAT; s++) begin
            if (tag_valid[s]) inflight = inflight + 1;
        end
        credits   = FIFO_DEPTH - int'(fifo_count) - inflight;
        // Nothing is granted while reset is held.
        can_issue = rstn && (credits > 0);
    end

    // Round-robin search starting at rr_ptr; first valid requester wins.
    always_comb begin
        grant    = 1'b0;
        grant_id = '0;
        idx      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (!grant && can_issue && req_valid[idx]) begin
                grant    = 1'b1;
                grant_id = ID_W'(idx);
            end
        end
        req_ready = grant ? (N_REQ'(1) << grant_id) : '0;
    end

    // Operand mux: the granted requester drives the adder this cycle.
    always_comb begin
        add_a = req_a[grant_id*FP16_W +: FP16_W];
        add_b = req_b[grant_id*FP16_W +: FP16_W];
    end

    fp_16_to_32_adder #(
        .LAT (ADD_LAT)
    ) u_adder (
        .clk       (clk),
        .rstn      (rstn),
        .fp_data_1 (add_a),
        .fp_data_2 (add_b),
        .data_out  (add_sum)
    );

    // Pointer advances past the winner; it holds when nobody is granted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= ID_W'(wrap_inc(int'(grant_id), N_REQ));
        end
    end

    // Tag pipeline mirrors the adder latency so the id meets its sum.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < ADD_LAT; s++) begin
                tag_valid[s] <= 1'b0;
                tag_id[s]    <= '0;
            end
        end else begin
            tag_valid[0] <= grant;
            tag_id[0]    <= grant_id;
            for (int s = 1; s < ADD_LAT; s++) begin
                tag_valid[s] <= tag_valid[s-1];
                tag_id[s]    <= tag_id[s-1];
            end
        end
    end

    assign push = tag_valid[ADD_LAT-1];
    assign pop  = res_valid && res_ready;

    // FIFO storage; contents are only observed through valid entries.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= add_sum;
            fifo_id[wr_ptr]   <= tag_id[ADD_LAT-1];
        end
    end

    // FIFO pointers and occupancy; credits make overflow impossible.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= PTR_W'(wrap_inc(int'(wr_ptr), FIFO_DEPTH));
            if (pop)  rd_ptr <= PTR_W'(wrap_inc(int'(rd_ptr), FIFO_DEPTH));
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Head of FIFO presented to the consumer; zero when empty.
    always_comb begin
        res_valid = (fifo_count != '0);
        res_data  = res_valid ? fifo_data[rd_ptr] : '0;
        res_id    = res_valid ? fifo_id[rd_ptr] : '0;
        busy      = (inflight != 0) || (fifo_count != '0);
    end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Randomised bench for fp_add_arbiter: a real-arithmetic fp model and a
// round-robin/credit model predict every grant and every result.
module tb_fp_add_arbiter;

    localparam int N_REQ      = 4;
    localparam int ADD_LAT    = 1;
    localparam int FIFO_DEPTH = 4;
    localparam int ID_W       = $clog2(N_REQ);
    localparam int W          = 72;  // {avail_cycle[31:0], id[7:0], data[31:0]}

    logic                  clk;
    logic                  rstn;
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ*16-1:0]   req_a;
    logic [N_REQ*16-1:0]   req_b;
    logic                  res_valid;
    logic                  res_ready;
    logic [31:0]           res_data;
    logic [ID_W-1:0]       res_id;
    logic                  busy;

    logic [W-1:0]          exp_q[$];
    int                    n_chk = 0;
    int                    n_err = 0;
    int                    cyc   = 0;
    logic [N_REQ-1:0]      hs_seen = '0;

    fp_add_arbiter #(
        .N_REQ      (N_REQ),
        .ADD_LAT    (ADD_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rstn      = 1'b0;
        req_valid = '0;
        repeat (n) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // ---------------- reference model ----------------
    function automatic real pow2(input int k);
        real r;
        r = 1.0;
        if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
        else        for (int i = 0; i < -k; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real fp16_val(input logic [15:0] h);
        int  e, m;
        real mag;
        e = int'(h[14:10]);
        m = int'(h[9:0]);
        if (e == 0) mag = real'(m) * pow2(-24);
        else        mag = real'(1024 + m) * pow2(e - 25);
        return h[15] ? -mag : mag;
    endfunction

    function automatic logic [31:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        logic nan_a, nan_b, inf_a, inf_b, s;
        real  x, ax, q, fl, fr;
        int   e, mi;
        nan_a = (a[14:10] == 5'h1F) && (a[9:0] != 0);
        nan_b = (b[14:10] == 5'h1F) && (b[9:0] != 0);
        inf_a = (a[14:10] == 5'h1F) && (a[9:0] == 0);
        inf_b = (b[14:10] == 5'h1F) && (b[9:0] == 0);
        if (nan_a || nan_b) return 32'h7FC0_0000;
        if (inf_a && inf_b && (a[15] != b[15])) return 32'h7FC0_0000;
        if (inf_a) return {a[15], 8'hFF, 23'd0};
        if (inf_b) return {b[15], 8'hFF, 23'd0};
        x = fp16_val(a) + fp16_val(b);
        if (x == 0.0) return {a[15] & b[15], 31'd0};
        s  = (x < 0.0);
        ax = s ? -x : x;
        e  = 0;
        while (ax >= pow2(e + 1)) e++;
        while (ax < pow2(e)) e--;
        q  = ax * pow2(23 - e);
        fl = $floor(q);
        fr = q - fl;
        mi = $rtoi(fl);
        if (fr > 0.5 || (fr == 0.5 && (mi % 2) == 1)) mi++;
        if (mi == (1 << 24)) begin
            mi = 1 << 23;
            e++;
        end
        return {s, 8'(e + 127), 23'(mi - (1 << 23))};
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    int           m_rr  = 0;
    int           m_out = 0;
    int           exp_g;
    int           mi_idx;
    logic [N_REQ-1:0] exp_ready;
    logic         head_ok;
    logic [W-1:0] head;

    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                check("rst_req_ready", 64'(req_ready), 64'(0));
                check("rst_res_valid", 64'(res_valid), 64'(0));
                check("rst_res_data",  64'(res_data),  64'(0));
                check("rst_res_id",    64'(res_id),    64'(0));
                check("rst_busy",      64'(busy),      64'(0));
                exp_q.delete();
                m_rr    = 0;
                m_out   = 0;
                hs_seen = '0;
            end else begin
                // Expected grant: first valid requester from the rr pointer, if a credit is free.
                exp_g = -1;
                if (m_out < FIFO_DEPTH) begin
                    for (int k = 0; k < N_REQ; k++) begin
                        mi_idx = (m_rr + k) % N_REQ;
                        if (exp_g < 0 && req_valid[mi_idx]) exp_g = mi_idx;
                    end
                end
                exp_ready = (exp_g >= 0) ? N_REQ'(1) << exp_g : '0;
                check("req_ready", 64'(req_ready), 64'(exp_ready));

                head    = (exp_q.size() > 0) ? exp_q[0] : '0;
                head_ok = (exp_q.size() > 0) && (int'(head[71:40]) <= cyc);
                check("res_valid", 64'(res_valid), 64'(head_ok));
                check("busy", 64'(busy), 64'(m_out > 0));
                if (head_ok && res_valid) begin
                    check("res_data", 64'(res_data), 64'(head[31:0]));
                    check("res_id",   64'(res_id),   64'(head[39:32]));
                end

                hs_seen = req_valid & req_ready;

                if (exp_g >= 0) begin
                    exp_q.push_back({32'(cyc + ADD_LAT + 1), 8'(exp_g),
                                     ref_add(req_a[exp_g*16 +: 16], req_b[exp_g*16 +: 16])});
                    m_rr  = (exp_g + 1) % N_REQ;
                    m_out = m_out + 1;
                end
                if (head_ok && res_ready) begin
                    void'(exp_q.pop_front());
                    m_out = m_out - 1;
                end
            end
        end
    end

    // ---------------- drivers ----------------
    function automatic logic [15:0] rand_fp16();
        logic [4:0] e;
        e = ($urandom_range(0, 15) == 0) ? 5'h1F : 5'($urandom_range(0, 30));
        return {1'($urandom_range(0, 1)), e, 10'($urandom_range(0, 1023))};
    endfunction

    // ready_mode: 0 always ready, 1 toggle, 2 random, 3 never ready.
    // max_ops 0 means unlimited; drop_pct gives idle cycles and abandoned requests.
    task automatic run_traffic(input int ncyc, input logic [N_REQ-1:0] mask,
                               input int ready_mode, input bit fixed,
                               input logic [15:0] fa, input logic [15:0] fb,
                               input int max_ops, input int drop_pct);
        int launched;
        logic [15:0] a;
        launched = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       res_ready = 1'b1;
                1:       res_ready = ~res_ready;
                2:       res_ready = 1'($urandom_range(0, 1));
                default: res_ready = 1'b0;
            endcase
            for (int i = 0; i < N_REQ; i++) begin
                if (!mask[i]) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] || hs_seen[i]) begin
                    if ((max_ops != 0 && launched >= max_ops) ||
                        (int'($urandom_range(0, 99)) < drop_pct)) begin
                        req_valid[i] = 1'b0;
                    end else begin
                        a = fixed ? fa : rand_fp16();
                        req_a[i*16 +: 16] = a;
                        req_b[i*16 +: 16] = fixed ? fb :
                            (($urandom_range(0, 7) == 0) ? (a ^ 16'h8000) : rand_fp16());
                        req_valid[i] = 1'b1;
                        launched++;
                    end
                end else if (int'($urandom_range(0, 199)) < drop_pct) begin
                    // Abandon a pending request before it is accepted.
                    req_valid[i] = 1'b0;
                    launched--;
                end
            end
        end
    endtask

    task automatic drain(input int ncyc);
        run_traffic(ncyc, '0, 0, 1'b0, 16'h0, 16'h0, 0, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rstn      = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        req_valid = '0;
        rstn      = 1'b1;

        // Single request 1.0 + 2.0 from requester 0.
        run_traffic(8, 4'b0001, 0, 1'b1, 16'h3C00, 16'h4000, 1, 0);

        // All requesters continuously valid from reset, consumer always ready.
        do_reset(2);
        run_traffic(40, 4'b1111, 0, 1'b0, 16'h0, 16'h0, 0, 0);
        drain(8);

        // Consumer stalled: credits run out, then the backlog drains in order.
        run_traffic(10, 4'b1111, 3, 1'b0, 16'h0, 16'h0, 0, 0);
        run_traffic(20, 4'b1111, 0, 1'b0, 16'h0, 16'h0, 0, 0);
        drain(8);

        // Requester 2 alone, 0.5 + 1.0, consumer toggling; 20 operations.
        run_traffic(90, 4'b0100, 1, 1'b1, 16'h3800, 16'h3C00, 20, 0);
        drain(8);

        // Random masks, random consumer, idle and abandoned requests.
        for (int r = 0; r < 6; r++) begin
            run_traffic(50, N_REQ'($urandom_range(1, 15)), 2, 1'b0, 16'h0, 16'h0, 0, 25);
        end
        drain(12);

        // Reset with three results queued and one in flight.
        run_traffic(4, 4'b1111, 3, 1'b0, 16'h0, 16'h0, 0, 0);
        do_reset(2);
        run_traffic(10, 4'b0001, 0, 1'b1, 16'h3C00, 16'h3C00, 1, 0);
        drain(12);

        check("final_queue_empty", 64'(exp_q.size()), 64'(0));
        check("final_busy", 64'(busy), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fp_add_arbiter.md
FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter ADD_LAT, default 1: clock cycles from adder operand input to registered data_out.
REQ-003 Parameter FIFO_DEPTH, default 4: result FIFO entries; SHALL be >= ADD_LAT+1.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rstn  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  N_REQ  per-requester operand-pair valid.
REQ-007 req_ready  out  N_REQ  per-requester accept; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-008 req_a  in  N_REQ*16  fp16 operand A, requester i at bits [16i+15:16i].
REQ-009 req_b  in  N_REQ*16  fp16 operand B, same packing.
REQ-010 res_valid  out  1  result available.
REQ-011 res_ready  in  1  result consumer accept.
REQ-012 res_data  out  32  fp32 sum A+B.
REQ-013 res_id  out  clog2(N_REQ)  index of the originating requester.
REQ-014 busy  out  1  high while any operation is in flight or the FIFO is non-empty.

Function
REQ-015 At most one requester SHALL be granted per cycle; req_ready SHALL be one-hot or zero.
REQ-016 Arbitration: round-robin; the search starts at rr_ptr; after a grant to i, rr_ptr <= (i+1) mod N_REQ; with no grant, rr_ptr holds.
REQ-017 A grant SHALL be issued only when credits > 0, where credits = FIFO_DEPTH - fifo_count - inflight, sampled at the start of the cycle; a FIFO pop frees its credit from the next cycle onward.
REQ-018 The granted requester's req_a/req_b SHALL drive the adder inputs in the grant cycle through a combinational mux.
REQ-019 A tag pipeline (valid plus id), ADD_LAT stages deep, SHALL track each issue; the adder output is pushed into the FIFO when the tag valid emerges.
REQ-020 With the FIFO empty and res_ready high, res_valid SHALL assert exactly ADD_LAT+1 cycles after the request handshake cycle.
REQ-021 Results SHALL leave in issue order; res_data and res_id SHALL be held stable while res_valid=1 and res_ready=0.
REQ-022 A simultaneous FIFO push and pop leaves fifo_count unchanged; overflow is impossible by REQ-017, and pop on empty is ignored.
REQ-023 Back-to-back grants SHALL be sustained at 1 per cycle while credits remain and res_ready=1.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; non-power-of-two depths SHALL be supported.
REQ-025 Dropping req_valid before the handshake SHALL be permitted and SHALL NOT alter rr_ptr.

Reset
REQ-026 While rstn=0: req_ready=0, res_valid=0, res_data=0, res_id=0, busy=0, rr_ptr=0, tag pipeline cleared, FIFO empty.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight and queued results; no res_valid SHALL appear for them after release.
REQ-028 The first grant SHALL be possible in the first rising edge after rstn deasserts.

Structure
REQ-029 Package fp_sched_pkg SHALL hold FP16_W=16, FP32_W=32, and the default N_REQ, ADD_LAT and FIFO_DEPTH.
REQ-030 The adder SHALL be one instance of the existing fp_16_to_32_adder (ports clk, rstn, fp_data_1, fp_data_2, data_out); arbiter, tag pipeline and FIFO stay inline.

Verification
REQ-031 Single request: req 0 A=0x3C00, B=0x4000 -> one cycle of res_valid after ADD_LAT+1 cycles, res_data=0x40400000, res_id=0.
REQ-032 All four requesters valid continuously from reset, res_ready=1 -> grants 0,1,2,3,0,... one per cycle, res_id in the same order.
REQ-033 res_ready=0, all requesters valid -> exactly FIFO_DEPTH grants, then req_ready=0; raising res_ready drains 4 results in order, then grants resume.
REQ-034 Requester 2 only, A=0x3800, B=0x3C00, with res_ready toggling every cycle -> res_data=0x3FC00000 held stable while stalled, no loss or duplication over 20 ops.
REQ-035 rstn pulsed low with 3 results queued and 1 in flight -> no res_valid after release; next request 0x3C00+0x3C00 returns 0x40000000 with the normal latency.
